// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, performs one memory read at a time over
// req/ack and holds the returned word for decode under valid/ready. Downstream
// branch redirects squash the held or in-flight instruction.
module fetch_unit #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [31:0]           imem_rdata,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [31:0]           instr,
    output logic [6:0]            instr_opcode,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    output logic [31:0]           retired_count
);

    localparam logic [1:0] S_FETCH = 2'd0;  // request outstanding
    localparam logic [1:0] S_HOLD  = 2'd1;  // instruction held for downstream
    localparam logic [1:0] S_DROP  = 2'd2;  // request outstanding, data to be discarded

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] pend_q, pend_d;
    logic [31:0]           instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic                  valid_q, valid_d;
    logic [31:0]           retired_q, retired_d;
    // Low for the first cycle after reset so imem_req stays 0 until rst has been seen high.
    logic                  req_en_q, req_en_d;

    logic                  ack;
    logic [ADDR_WIDTH-1:0] tgt_aligned;
    logic                  unused_tgt_bits;

    assign tgt_aligned     = {redirect_target[ADDR_WIDTH-1:2], 2'b00};
    assign unused_tgt_bits = ^redirect_target[1:0];

    // Outputs decoded from registers only.
    assign imem_req      = req_en_q & ((state_q == S_FETCH) | (state_q == S_DROP));
    assign imem_addr     = pc_q;
    assign instr_valid   = valid_q;
    assign instr         = instr_q;
    assign instr_opcode  = instr_q[6:0];
    assign instr_pc      = instr_pc_q;
    assign retired_count = retired_q;

    // Acks without an active request are ignored.
    assign ack = imem_req & imem_ack;

    // Next-state: handshake progress, with redirect taking priority.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        retired_d  = retired_q;
        req_en_d   = 1'b1;
        unique case (state_q)
            S_FETCH: begin
                if (redirect) begin
                    if (ack || !req_en_q) begin
                        pc_d = tgt_aligned;
                    end else begin
                        // Cannot move the address mid-transaction; finish it first.
                        pend_d  = tgt_aligned;
                        state_d = S_DROP;
                    end
                end else if (ack) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    valid_d    = 1'b1;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    retired_d = retired_q + 32'd1;
                end
                if (redirect) begin
                    valid_d = 1'b0;
                    pc_d    = tgt_aligned;
                    state_d = S_FETCH;
                end else if (instr_ready) begin
                    valid_d = 1'b0;
                    pc_d    = pc_q + ADDR_WIDTH'(4);
                    state_d = S_FETCH;
                end
            end
            S_DROP: begin
                if (ack) begin
                    pc_d    = redirect ? tgt_aligned : pend_q;
                    state_d = S_FETCH;
                end else if (redirect) begin
                    pend_d = tgt_aligned;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = S_FETCH;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            pend_q     <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            retired_q  <= '0;
            req_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            retired_q  <= retired_d;
            req_en_q   <= req_en_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: a driver issues memory, ready,
// redirect and reset stimulus and queues the next expected instruction address;
// a monitor checks each delivered instruction and the register outputs.
module tb_fetch_unit;

    localparam int unsigned AW       = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic          instr_valid;
    logic          instr_ready;
    logic [31:0]   instr;
    logic [6:0]    instr_opcode;
    logic [AW-1:0] instr_pc;
    logic          redirect;
    logic [AW-1:0] redirect_target;
    logic [31:0]   retired_count;

    fetch_unit #(
        .ADDR_WIDTH (AW),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_opcode    (instr_opcode),
        .instr_pc        (instr_pc),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .retired_count   (retired_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    int unsigned cnt_model = 0;

    // Memory contents as a fixed function of the word address.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver: memory responder, random ready/redirect/reset, reference model.
    initial begin
        logic        v, rq, busy, n_rst, n_ready, n_redir, n_ack;
        logic [31:0] addr, busy_addr, tgt, n_rdata, exp_pc;
        int          wait_cnt, rst_left;

        rst = 1'b0; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        redirect = 1'b0; redirect_target = '0;
        busy = 1'b0; busy_addr = '0; wait_cnt = 0; rst_left = 3;
        exp_pc = RESET_PC;
        exp_q.push_back(exp_pc);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            v    = instr_valid;
            rq   = imem_req;
            addr = imem_addr;

            if (rst_left == 0 && $urandom_range(0, 299) == 0) rst_left = $urandom_range(1, 3);
            n_rst = (rst_left == 0);
            if (rst_left > 0) rst_left--;
            n_ready = ($urandom_range(0, 9) < 6);
            n_redir = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 3))
                0:       tgt = 32'h0000_0103;
                1:       tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                2:       tgt = $urandom & 32'h0000_FFFF;
                default: tgt = $urandom;
            endcase

            // Memory: random 0-3 cycle latency per request; stray acks while idle.
            n_ack = 1'b0;
            if (rq) begin
                chk("addr_align", {30'd0, addr[1:0]}, 32'd0);
                if (!busy) begin
                    busy      = 1'b1;
                    wait_cnt  = $urandom_range(0, 3);
                    busy_addr = addr;
                end else begin
                    chk("addr_stable", addr, busy_addr);
                end
                if (wait_cnt == 0) begin
                    n_ack = 1'b1;
                    busy  = 1'b0;
                end else begin
                    wait_cnt--;
                end
            end else begin
                busy  = 1'b0;
                n_ack = ($urandom_range(0, 4) == 0);
            end
            if (!n_rst) busy = 1'b0;
            n_rdata = (rq && n_ack) ? mem_f(addr) : $urandom;

            // Reference model: the address of the next instruction to be delivered.
            if (!n_rst) begin
                exp_pc    = RESET_PC;
                cnt_model = 0;
                exp_q.delete();
                exp_q.push_back(exp_pc);
            end else begin
                if (v && n_ready) cnt_model++;
                if (n_redir) begin
                    exp_pc = {tgt[31:2], 2'b00};
                    exp_q.delete();
                    exp_q.push_back(exp_pc);
                end else if (v && n_ready) begin
                    exp_pc = exp_pc + 32'd4;
                    exp_q.delete();
                    exp_q.push_back(exp_pc);
                end
            end

            rst             = n_rst;
            instr_ready     = n_ready;
            redirect        = n_redir;
            redirect_target = tgt;
            imem_ack        = n_ack;
            imem_rdata      = n_rdata;
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Monitor: sample 1 time unit after each rising edge.
    initial begin
        logic        prev_valid;
        logic [31:0] prev_instr, prev_pc, e;
        int          idle;
        prev_valid = 1'b0; prev_instr = '0; prev_pc = '0; idle = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                chk("rst_req",     {31'd0, imem_req}, 32'd0);
                chk("rst_valid",   {31'd0, instr_valid}, 32'd0);
                chk("rst_instr",   instr, 32'd0);
                chk("rst_pc",      instr_pc, 32'd0);
                chk("rst_retired", retired_count, 32'd0);
                prev_valid = 1'b0;
                idle       = 0;
            end else begin
                chk("retired", retired_count, cnt_model);
                chk("req_while_valid", {31'd0, imem_req & instr_valid}, 32'd0);
                if (instr_valid && !prev_valid) begin
                    idle = 0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_instr", instr_pc, 32'hDEAD_BEEF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("instr_pc", instr_pc, e);
                        chk("instr", instr, mem_f(e));
                        chk("opcode", {25'd0, instr_opcode}, {25'd0, mem_f(e) & 32'h7F});
                    end
                end else if (instr_valid && prev_valid) begin
                    chk("hold_instr", instr, prev_instr);
                    chk("hold_pc", instr_pc, prev_pc);
                end
                if (!instr_valid) begin
                    idle++;
                    if (idle > 100) begin
                        chk("watchdog_no_instr", 32'd0, 32'd1);
                        idle = 0;
                    end
                end
                prev_valid = instr_valid;
            end
            prev_instr = instr;
            prev_pc    = instr_pc;
        end
    end

endmodule
